// File: rtl/fifo_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and field layout for the FIFO write arbiter   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // fifo_wr_data layout, MSB to LSB: {owner id, last, payload}
    function automatic int wr_data_width(input int idw, input int w);
        return idw + 1 + w;
    endfunction

    function automatic int wr_last_pos(input int w);
        return w;
    endfunction

    function automatic int wr_id_lsb(input int w);
        return w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin selector, first set bit at/after ptr  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            found,
    output logic [IDW-1:0]  index
);

    logic [2*NREQ-1:0] w_dbl;
    logic [2*NREQ-1:0] w_shift;
    logic [NREQ-1:0]   w_rot;
    int                w_sum;

    // Rotating the doubled vector puts the requester at rr_ptr in bit 0.
    always_comb begin
        w_dbl   = {req, req};
        w_shift = w_dbl >> rr_ptr;
        w_rot   = w_shift[NREQ-1:0];
        found   = 1'b0;
        index   = '0;
        w_sum   = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                found = 1'b1;
                w_sum = (int'(rr_ptr) + j) % NREQ;
                index = IDW'(w_sum);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// +----------------------------------------------------------------------------+
// | fifo_wr_arb : round-robin burst arbiter feeding one FIFO write port       |
// | Revision    : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int W         = 8,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*W-1:0]    req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic                 fifo_wr_en,
    output logic [IDW+1+W-1:0]   fifo_wr_data,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic [IDW-1:0]       gnt_id
);

    localparam int c_BCW = $clog2(MAX_BURST) + 1;
    localparam int c_DW  = wr_data_width(IDW, W);

    arb_state_t       r_state;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   r_rr_ptr;
    logic [c_BCW-1:0] r_beat_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_pick;
    logic             w_owner_valid;
    logic             w_owner_last;
    logic [W-1:0]     w_owner_data;
    logic             w_in_burst;
    logic             w_wr;
    logic             w_at_limit;
    logic [IDW-1:0]   w_next_ptr;
    logic [c_DW-1:0]  w_wr_data;

    rr_pick #(
        .NREQ   (NREQ)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .index  (w_pick)
    );

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_owner_data  = req_data[int'(r_owner)*W +: W];

    // Reset gates the strobe so an in-flight beat is never half-written.
    assign w_in_burst = (r_state == ST_BURST) && !reset;
    assign w_wr       = w_in_burst && w_owner_valid && !fifo_full;
    assign w_at_limit = (r_beat_cnt == c_BCW'(MAX_BURST - 1));
    assign w_next_ptr = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
    assign w_wr_data  = {r_owner, w_owner_last, w_owner_data};

    always_comb begin
        req_ack = '0;
        if (w_wr) begin
            req_ack[r_owner] = 1'b1;
        end
    end

    assign fifo_wr_en   = w_wr;
    assign fifo_wr_data = w_wr_data;
    assign busy         = w_in_burst;
    assign gnt_id       = reset ? '0 : r_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!w_owner_valid) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_wr) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_owner_last || w_at_limit) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_wr_arb : randomized scoreboard bench for fifo_wr_arb              |
// | Revision       : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;
    localparam int DW        = IDW + 1 + W;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_full;
    logic              busy;
    logic [IDW-1:0]    gnt_id;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NREQ         (NREQ),
        .W            (W),
        .MAX_BURST    (MAX_BURST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .gnt_id       (gnt_id)
    );

    typedef struct packed {
        logic            busy;
        logic [IDW-1:0]  gnt;
        logic            wr;
        logic [NREQ-1:0] ack;
    } status_t;

    status_t       st_q[$];
    logic [DW-1:0] wr_q[$];
    int            checks = 0;
    int            passed = 0;

    // Requester sources: each holds one packet of len beats at a time.
    bit            active[NREQ];
    int            len[NREQ];
    int            idx[NREQ];
    logic [W-1:0]  cur[NREQ];
    int            start_pct, drop_pct, full_pct, stall_left;

    // Reference model: grant holder, beats written this grant, next search start.
    bit            m_busy;
    int            m_owner, m_ptr, m_beats;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic release_grant();
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
    endtask

    task automatic step(input bit rst);
        status_t s;
        bit      lst;
        reset = rst;
        for (int i = 0; i < NREQ; i++) begin
            if (!active[i] && $urandom_range(99) < start_pct) begin
                active[i] = 1'b1;
                len[i]    = $urandom_range(7, 1);
                idx[i]    = 0;
                cur[i]    = W'($urandom);
            end
            req_valid[i]       = active[i] && ($urandom_range(99) >= drop_pct);
            req_last[i]        = active[i] && (idx[i] == len[i] - 1);
            req_data[i*W +: W] = cur[i];
        end
        if (stall_left > 0) begin
            fifo_full = 1'b1;
            stall_left--;
        end else if ($urandom_range(99) < full_pct) begin
            fifo_full  = 1'b1;
            stall_left = $urandom_range(4, 0);
        end else begin
            fifo_full = 1'b0;
        end

        s = '0;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
        end else if (!m_busy) begin
            s.gnt = IDW'(m_owner);
            for (int k = 0; k < NREQ; k++) begin
                if (!m_busy && req_valid[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end
        end else begin
            s.busy = 1'b1;
            s.gnt  = IDW'(m_owner);
            if (!req_valid[m_owner]) begin
                release_grant();
            end else if (!fifo_full) begin
                lst = req_last[m_owner];
                s.wr = 1'b1;
                s.ack[m_owner] = 1'b1;
                wr_q.push_back({IDW'(m_owner), lst, cur[m_owner]});
                m_beats++;
                idx[m_owner]++;
                cur[m_owner] = W'($urandom);
                if (idx[m_owner] == len[m_owner]) active[m_owner] = 1'b0;
                if (lst || m_beats == MAX_BURST) release_grant();
            end
        end
        st_q.push_back(s);
    endtask

    // Monitor: one status record per cycle, one data record per DUT write.
    initial begin
        status_t       e;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("busy",    int'(busy),       int'(e.busy));
                check("gnt_id",  int'(gnt_id),     int'(e.gnt));
                check("wr_en",   int'(fifo_wr_en), int'(e.wr));
                check("req_ack", int'(req_ack),    int'(e.ack));
                if (fifo_wr_en === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        ed = wr_q.pop_front();
                        check("wr_data", int'(fifo_wr_data), int'(ed));
                    end
                end
            end
        end
    end

    initial begin
        int  cyc;
        bit  rst;
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        start_pct = 0; drop_pct = 0; full_pct = 0; stall_left = 0;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
        for (int i = 0; i < NREQ; i++) begin
            active[i] = 1'b0; len[i] = 0; idx[i] = 0; cur[i] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            step(1'b1);
        end
        for (int c = 0; c < 4000; c++) begin
            if (c < 1000)      begin start_pct = 100; drop_pct = 0;  full_pct = 0;  end
            else if (c < 2500) begin start_pct = 30;  drop_pct = 10; full_pct = 10; end
            else               begin start_pct = 50;  drop_pct = 0;  full_pct = 20; end
            rst = (c > 20) && ($urandom_range(299) == 0);
            @(posedge clk); #1;
            step(rst);
        end
        start_pct = 0; drop_pct = 0; full_pct = 0;
        cyc = 0;
        while (cyc < 500 && (m_busy || active[0] || active[1] || active[2] || active[3])) begin
            @(posedge clk); #1;
            step(1'b0);
            cyc++;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            step(1'b0);
        end
        @(negedge clk); #1;
        check("drain_budget",   int'(cyc < 500), 1);
        check("status_q_empty", st_q.size(), 0);
        check("write_q_empty",  wr_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
